// File: rtl/pcie_pkg.sv
// Shared receive-path constants and deskew state encoding.
package pcie_pkg;
  localparam logic [7:0] COM          = 8'hBC;
  localparam int         NUM_LANES    = 4;
  localparam int         DESKEW_DEPTH = 4;

  typedef enum logic {
    SEARCH  = 1'b0,
    ALIGNED = 1'b1
  } deskew_state_e;
endpackage

// File: rtl/lane_deskew_if.sv
// Lane-side and aligned-side signals of the four-lane deskew stage.
interface lane_deskew_if;
  import pcie_pkg::*;

  logic [NUM_LANES-1:0]      in_valid;
  logic [NUM_LANES-1:0][7:0] lane;
  logic [NUM_LANES-1:0][7:0] out_data;
  logic                      out_valid;
  logic                      aligned;
  logic                      skew_err;

  modport master (
    output in_valid, lane,
    input  out_data, out_valid, aligned, skew_err
  );

  modport slave (
    input  in_valid, lane,
    output out_data, out_valid, aligned, skew_err
  );
endinterface

// File: rtl/deskew_lane_fifo.sv
// Per-lane COM-locked circular buffer; discards bytes until the first COM.
module deskew_lane_fifo
  import pcie_pkg::*;
#(
  parameter int DEPTH = DESKEW_DEPTH
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_valid_i,
  input  logic [7:0] wr_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       locked_o,
  output logic       wr_en_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          locked_q;
  logic          wr_en;

  assign wr_en    = wr_valid_i && (locked_q || wr_data_i == COM);
  assign wr_en_o  = wr_en;
  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign locked_o = locked_q;
  assign head_o   = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i && !reset_i) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      locked_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        locked_q <= 1'b1;
        wptr_q   <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop_i) rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      case ({wr_en, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/lane_deskew.sv
// Four-lane COM deskew: releases lock-stepped tuples, flushes on skew faults.
// Optional re-acquisition counter enabled by LANE_DESKEW_STATS_EN.
//
//   state   | meaning
//   SEARCH  | waiting for every lane to lock and hold data; ALIGNED low
//   ALIGNED | at least one good tuple released since the last flush
module lane_deskew
  import pcie_pkg::*;
#(
  parameter int DEPTH = DESKEW_DEPTH
) (
  input  logic          clk_i,
  input  logic          reset_i,
  lane_deskew_if.slave  bus
`ifdef LANE_DESKEW_STATS_EN
  ,
  output logic [7:0]    resync_cnt_o
`endif
);
  localparam int CNT_W = $clog2(NUM_LANES + 1);

  logic [NUM_LANES-1:0]      empty, full, locked, wr_en, ovf;
  logic [NUM_LANES-1:0][7:0] head;
  logic [CNT_W-1:0]          com_cnt;
  logic                      pop, misalign, err;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    deskew_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .wr_valid_i (bus.in_valid[g]),
      .wr_data_i  (bus.lane[g]),
      .pop_i      (pop),
      .flush_i    (err),
      .head_o     (head[g]),
      .empty_o    (empty[g]),
      .full_o     (full[g]),
      .locked_o   (locked[g]),
      .wr_en_o    (wr_en[g])
    );
  end

  assign pop = (&locked) && !(|empty);

  always_comb begin
    com_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) com_cnt = com_cnt + CNT_W'(head[i] == COM);
  end

  // A full lane may still accept a byte when the same edge pops it.
  assign ovf      = wr_en & full & {NUM_LANES{~pop}};
  assign misalign = pop && (com_cnt != '0) && (com_cnt != CNT_W'(NUM_LANES));
  assign err      = misalign || (|ovf);

  deskew_state_e             state_q;
  logic [NUM_LANES-1:0][7:0] out_q;
  logic                      out_valid_q, skew_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= SEARCH;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skew_err_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      skew_err_q  <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (err) begin
            skew_err_q <= 1'b1;
          end else if (pop) begin
            out_q       <= head;
            out_valid_q <= 1'b1;
            state_q     <= ALIGNED;
          end
        end
        ALIGNED: begin
          if (err) begin
            skew_err_q <= 1'b1;
            state_q    <= SEARCH;
          end else if (pop) begin
            out_q       <= head;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.skew_err  = skew_err_q;
  assign bus.aligned   = (state_q == ALIGNED);

`ifdef LANE_DESKEW_STATS_EN
  logic [7:0] resync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resync_q <= '0;
    end else if (err && resync_q != 8'hFF) begin
      resync_q <= resync_q + 8'd1;
    end
  end

  assign resync_cnt_o = resync_q;
`endif
endmodule

// File: tb/tb_lane_deskew.sv
// Bench for lane_deskew: queue-based reference model plus directed and random lane traffic.
module tb_lane_deskew;
  import pcie_pkg::*;

  localparam int DEPTH = DESKEW_DEPTH;

  logic clk;
  logic reset;
  lane_deskew_if dif();
`ifdef LANE_DESKEW_STATS_EN
  logic [7:0] resync_cnt;
`endif

  lane_deskew #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (dif)
`ifdef LANE_DESKEW_STATS_EN
    ,
    .resync_cnt_o (resync_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per lane, evaluated at each clock edge.
  logic [7:0]  mq [4][$];
  bit          mlock [4];
  bit          m_wr [4];
  bit          m_pop, m_ovf, m_started;
  int          m_ncom;
  logic [31:0] e_out;
  bit          e_valid, e_aligned, e_err;
  int          e_resync;

  initial m_started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        mlock[i] = 1'b0;
      end
      e_out = '0; e_valid = 0; e_aligned = 0; e_err = 0; e_resync = 0;
      m_started = 1'b1;
    end else begin
      m_pop = 1; m_ncom = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) if (!mlock[i] || mq[i].size() == 0) m_pop = 0;
      for (int i = 0; i < 4; i++) m_wr[i] = dif.in_valid[i] && (mlock[i] || dif.lane[i] == COM);
      if (m_pop) for (int i = 0; i < 4; i++) if (mq[i][0] == COM) m_ncom++;
      for (int i = 0; i < 4; i++) if (m_wr[i] && !m_pop && mq[i].size() == DEPTH) m_ovf = 1;
      e_valid = 0; e_err = 0;
      if (m_ovf || (m_ncom > 0 && m_ncom < 4)) begin
        e_err = 1; e_aligned = 0;
        for (int i = 0; i < 4; i++) begin
          mq[i].delete();
          mlock[i] = 1'b0;
        end
        if (e_resync < 255) e_resync++;
      end else begin
        if (m_pop) begin
          for (int i = 0; i < 4; i++) e_out[i*8 +: 8] = mq[i].pop_front();
          e_valid = 1; e_aligned = 1;
        end
        for (int i = 0; i < 4; i++) if (m_wr[i]) begin
          mq[i].push_back(dif.lane[i]);
          mlock[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("out_valid", 32'(dif.out_valid), 32'(e_valid));
      chk("out_data",  dif.out_data,       e_out);
      chk("aligned",   32'(dif.aligned),   32'(e_aligned));
      chk("skew_err",  32'(dif.skew_err),  32'(e_err));
`ifdef LANE_DESKEW_STATS_EN
      chk("resync_cnt", 32'(resync_cnt), 32'(e_resync));
`endif
    end
  end

  task automatic step(input logic [3:0] v, input logic [31:0] b);
    dif.in_valid = v;
    dif.lane     = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(4'h0, 32'h0);
    step(4'h0, 32'h0);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] nocom(input logic [7:0] b);
    return (b == COM) ? 8'h3C : b;
  endfunction

  // Each lane sends 00 until its delay expires, then COM, 1, 2, ...
  task automatic run_skew(input int d0, input int d1, input int d2, input int d3, input int n,
                          output int first_v, output int first_e, output logic [31:0] first_data);
    int          d [4];
    int          idx;
    logic [31:0] b;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    first_v = -1; first_e = -1; first_data = '0;
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < 4; i++) begin
        idx = t - d[i];
        b[i*8 +: 8] = (idx < 0) ? 8'h00 : (idx == 0) ? COM : 8'(idx);
      end
      step(4'hF, b);
      if (dif.out_valid && first_v < 0) begin
        first_v    = t;
        first_data = dif.out_data;
      end
      if (dif.skew_err && first_e < 0) first_e = t;
    end
  endtask

  task automatic gap_test();
    int          k [4];
    int          nt, gaps, pend, nerr;
    bit          seen;
    logic [3:0]  v;
    logic [31:0] b;
    for (int i = 0; i < 4; i++) k[i] = 0;
    nt = 0; gaps = 0; pend = 0; seen = 0; nerr = 0;
    for (int s = 0; s < 18; s++) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = (i == 0) ? (!(s == 4 || s == 5) && k[0] < 12) : (k[i] < 12);
        b[i*8 +: 8] = (k[i] == 0) ? COM : 8'(8'h10 + k[i]);
        if (v[i]) k[i]++;
      end
      step(v, b);
      if (dif.skew_err) nerr++;
      if (dif.out_valid) begin
        nt++;
        if (seen) gaps += pend;
        pend = 0;
        seen = 1;
      end else if (seen) begin
        pend++;
      end
    end
    chk("gap_tuples", 32'(nt), 32'd12);
    chk("gap_idle",   32'(gaps), 32'd2);
    chk("gap_no_err", 32'(nerr), 32'd0);
  endtask

  logic [7:0] src [256][4];

  task automatic rand_skew_seg(input int n);
    int          d [4];
    int          p [4];
    logic [3:0]  v;
    logic [31:0] b;
    for (int c = 0; c < 256; c++)
      for (int i = 0; i < 4; i++)
        src[c][i] = (c % 12 == 0) ? COM : nocom(8'($urandom));
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom_range(0, 4);
      p[i] = 0;
    end
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (t < d[i]) begin
          v[i] = 1'b1;
          b[i*8 +: 8] = 8'h00;
        end else begin
          v[i] = ($urandom_range(0, 39) != 0);
          b[i*8 +: 8] = src[p[i]][i];
          if (v[i]) p[i]++;
        end
      end
      step(v, b);
    end
  endtask

  task automatic rand_free(input int n);
    logic [31:0] b;
    for (int t = 0; t < n; t++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 4; i++) b[i*8 +: 8] = ($urandom_range(0, 6) == 0) ? COM : 8'($urandom);
      step(4'($urandom), b);
    end
    reset = 1'b0;
  endtask

  initial begin
    int          fv, fe, npulse;
    logic [31:0] fd;

    reset = 1'b1;
    dif.in_valid = '0;
    dif.lane = '0;
    @(negedge clk);
    do_reset();
    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_out_data",  dif.out_data,       32'h0);
    chk("rst_aligned",   32'(dif.aligned),   32'd0);

    // zero skew
    step(4'hF, 32'hBCBCBCBC);
    chk("zs_no_early", 32'(dif.out_valid), 32'd0);
    step(4'hF, 32'h01010101);
    chk("zs_t0_valid", 32'(dif.out_valid), 32'd1);
    chk("zs_t0_data",  dif.out_data,       32'hBCBCBCBC);
    chk("zs_aligned",  32'(dif.aligned),   32'd1);
    step(4'hF, 32'h02020202);
    chk("zs_t1_data",  dif.out_data,       32'h01010101);
    step(4'h0, 32'h0);
    chk("zs_t2_data",  dif.out_data,       32'h02020202);
    step(4'h0, 32'h0);
    chk("zs_gap_valid", 32'(dif.out_valid), 32'd0);
    chk("zs_hold_data", dif.out_data,       32'h02020202);

    // lane 2 three cycles late: tolerated
    do_reset();
    run_skew(0, 0, 3, 0, 10, fv, fe, fd);
    chk("sk3_first_t",    32'(fv), 32'd4);
    chk("sk3_first_data", fd,      32'hBCBCBCBC);
    chk("sk3_no_err",     32'(fe), 32'hFFFFFFFF);

    // lane 3 four cycles late: overflow when its COM arrives
    do_reset();
    run_skew(0, 0, 0, 4, 8, fv, fe, fd);
    chk("sk4_err_t",  32'(fe), 32'd4);
    chk("sk4_no_out", 32'(fv), 32'hFFFFFFFF);
    chk("sk4_unaligned", 32'(dif.aligned), 32'd0);
    step(4'hF, 32'hBCBCBCBC);
    step(4'hF, 32'h20202020);
    chk("reacq_aligned", 32'(dif.aligned), 32'd1);
    chk("reacq_data",    dif.out_data,     32'hBCBCBCBC);

    // stray COM on lane 1 only
    step(4'hF, 32'h5555BC55);
    chk("mis_prev_data", dif.out_data, 32'h20202020);
    step(4'hF, 32'h55555555);
    chk("mis_err",     32'(dif.skew_err),  32'd1);
    chk("mis_dropped", 32'(dif.out_valid), 32'd0);
    chk("mis_aligned", 32'(dif.aligned),   32'd0);
    step(4'hF, 32'h55555555);
    chk("mis_pulse_end", 32'(dif.skew_err), 32'd0);

    do_reset();
    gap_test();

    // reset while aligned
    do_reset();
    step(4'hF, 32'hBCBCBCBC);
    step(4'hF, 32'h33333333);
    reset = 1'b1;
    step(4'hF, 32'h44444444);
    reset = 1'b0;
    chk("rst2_valid",   32'(dif.out_valid), 32'd0);
    chk("rst2_data",    dif.out_data,       32'h0);
    chk("rst2_aligned", 32'(dif.aligned),   32'd0);

    // three forced misalignments
    npulse = 0;
    for (int r = 0; r < 3; r++) begin
      step(4'hF, 32'hBCBCBCBC);
      if (dif.skew_err) npulse++;
      step(4'hF, 32'h5555BC55);
      if (dif.skew_err) npulse++;
      step(4'hF, 32'h55555555);
      if (dif.skew_err) npulse++;
    end
    chk("err_pulses", 32'(npulse), 32'd3);
`ifdef LANE_DESKEW_STATS_EN
    chk("resync_three", 32'(resync_cnt), 32'd3);
`endif

    for (int s = 0; s < 4; s++) begin
      do_reset();
      rand_skew_seg(150);
    end
    do_reset();
    rand_free(300);
    step(4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lane_deskew.md
# lane_deskew

Four-lane receive deskew stage between the serial-to-parallel converters and the receive byte un-striper. Each lane's recovered bytes are buffered per lane. All lanes are aligned on the COM symbol (K28.5, 0xBC), then released as lock-stepped 4-byte tuples so the un-striper always sees bytes from the same striping column. Misalignment and overflow are detected and trigger automatic re-acquisition.

## Interface
- DEPTH, 4: entries per lane buffer; tolerated inter-lane skew = DEPTH-1 byte clocks
- COM, 8'hBC: alignment symbol
- CLK  in  1  byte clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  4  bit i = LANEi byte valid this cycle
- LANE0..LANE3  in  8 each  recovered lane bytes
- OUT0..OUT3  out  8 each  aligned lane bytes
- OUT_VALID  out  1  OUT0..OUT3 hold one aligned tuple this cycle
- ALIGNED  out  1  all lanes locked and streaming
- SKEW_ERR  out  1  one-cycle pulse on overflow/misalignment
- RESYNC_CNT  out  8  saturating re-acquisition count (only with LANE_DESKEW_STATS_EN)

## Operation
- Per-lane state: locked[i] flag, circular buffer, write/read pointers, count 0..DEPTH.
- Unlocked lane: bytes with IN_VALID[i]=1 and value != COM are discarded. The first COM sets locked[i] and is written as entry 0.
- Locked lane: every valid byte is written.
- Pop: occurs when all locked[i]=1 (registered flags) and all counts > 0. One entry is read from every lane. The tuple is registered onto OUT0..3, with OUT_VALID=1 for one cycle. ALIGNED is set on the first pop.
- Write and pop on the same lane in the same cycle is legal; the count is unchanged.
- Overflow: a lane at count=DEPTH writes without a pop in that cycle.
- Misalignment: a popped tuple has COM on 1–3 lanes, but not all 4.
- Error response, applied at the same edge for either fault:
  - pulse SKEW_ERR for one cycle
  - clear all locked flags, pointers and counts, and ALIGNED
  - discard that cycle's input bytes and popped tuple (OUT_VALID=0)
  - resume the search on the next edge
- All-COM tuples are legal and pass through unchanged.
- No pop while any lane is unlocked. OUT_VALID stays 0 during gaps.

## Timing
- Reset values: OUT0..3=0, OUT_VALID=0, ALIGNED=0, SKEW_ERR=0, RESYNC_CNT=0, all locked=0, all counts/pointers=0.
- RESET dominates any write, pop or error in the same cycle.
- Acquisition: last lane's COM sampled at edge n → after edge n+1, OUT_VALID=1, ALIGNED=1, OUT0..3=COM.
- Steady state: a byte sampled at edge n on the latest lane appears on OUT after edge n+1. Earlier lanes are delayed by their skew.
- Skew limit: a lane that locks k edges before the last lane holds k+1 entries at edge n.
  - k ≤ DEPTH-1 is accepted.
  - k = DEPTH overflows at edge n → SKEW_ERR after edge n.
- OUT0..3 hold their last values when OUT_VALID=0.

## Configuration
- LANE_DESKEW_STATS_EN defined:
  - RESYNC_CNT port present.
  - Increments on every SKEW_ERR pulse and saturates at 255.
  - Cleared only by RESET.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package pcie_pkg holds:
  - K28.5 COM constant 8'hBC
  - NUM_LANES=4
  - deskew state encoding: SEARCH, ALIGNED
- Sub-module deskew_lane_fifo, instantiated four times:
  - owns locked flag, buffer, pointers, count
  - inputs: write, pop, flush
  - outputs: head byte, empty, full
- Top level owns pop/error decision, output registers and stats counter.

## Test plan
- Zero skew: all lanes send COM, 0x01, 0x02 on consecutive edges → OUT_VALID tuples (BC,BC,BC,BC), (01×4), (02×4); ALIGNED=1 from the first tuple.
- LANE2 delayed 3 cycles (DEPTH=4) → same tuple sequence, first tuple 3 cycles later; SKEW_ERR never asserts.
- LANE3 delayed 4 cycles → SKEW_ERR pulse at the edge LANE3's COM arrives; ALIGNED=0. Subsequent aligned COMs → ALIGNED=1.
- After lock, inject COM on LANE1 only (others 0x55) → tuple dropped, SKEW_ERR=1 for one cycle, ALIGNED=0, re-search.
- IN_VALID[0]=0 for 2 cycles mid-stream → OUT_VALID=0 for 2 cycles, no byte lost or reordered, no SKEW_ERR.
- RESET asserted while ALIGNED=1 → next cycle all outputs 0. With LANE_DESKEW_STATS_EN, 3 forced errors → RESYNC_CNT=3.
